falafel_lsu_arbiter: RTL and testbench
======================================

# falafel_lsu_arbiter

- Shares the single falafel LSU request/response port between `N_REQ` requesters, e.g. the allocation and free paths of the allocator core.
- Arbitrates round-robin per LSU transaction.
- Once a requester's LOCK completes, that requester owns the LSU exclusively until its UNLOCK completes. Its LOCK / LOAD / EDIT / UNLOCK sequence on the free list is therefore never interleaved with another requester.
- Sits between the requesters and the LSU core-side port; the LSU memory side is untouched.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, ≥1.
- `IDX_W`, default `(N_REQ>1)?$clog2(N_REQ):1`: requester index width.

Ports:
- `clk_i` in 1: clock; one clock domain, no CDC.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_header_i[N_REQ]` in `header_req_t`: requester commands (`.val`, `.lsu_op`, `.header`).
- `req_ready_o[N_REQ]` out 1: request accepted this cycle.
- `rsp_header_o[N_REQ]` out `header_rsp_t`: per-requester response.
- `rsp_rdy_i[N_REQ]` in 1: requester ready for its response.
- `lsu_req_header_o` out `header_req_t`: to LSU `core_req_header_i`.
- `lsu_ready_i` in 1: from LSU `lsu_ready_o`.
- `lsu_rsp_header_i` in `header_rsp_t`: from LSU `core_rsp_header_o`.
- `lsu_core_rdy_o` out 1: to LSU `core_rdy_i`.
- `lock_held_o` out 1: lock currently owned.
- `lock_owner_o` out `IDX_W`: owning requester; valid when `lock_held_o` is 1.
- `err_o` out 1: one-cycle pulse on a protocol violation.

## Operation
State registers: `state_q` ∈ {IDLE, BUSY, LOCAL_RSP}, `cur_q` (requester being served), `rr_ptr_q`, `locked_q`, `owner_q`.

IDLE, eligibility:
- If `locked_q`, only `owner_q` is eligible.
- Otherwise every requester with `.val=1` is eligible.
- Winner = first eligible requester scanning `rr_ptr_q`, `rr_ptr_q+1`, … modulo `N_REQ`.

IDLE, winner handling:
- Winner's op is LOCK while `locked_q` (nested lock): not forwarded, since it would spin the LSU forever.
  - Assert `req_ready_o[w]` and pulse `err_o`.
  - Load `cur_q=w`; go to LOCAL_RSP.
- Any other op, when `lsu_ready_i`=1:
  - Drive `lsu_req_header_o = req_header_i[w]` with `.val=1`.
  - Assert `req_ready_o[w]`; load `cur_q=w`; go to BUSY.
- `lsu_ready_i`=0: drive nothing (`lsu_req_header_o.val=0`); stay in IDLE.
- No eligible requester: stay in IDLE.

BUSY:
- `rsp_header_o[cur_q] = lsu_rsp_header_i`; `lsu_core_rdy_o = rsp_rdy_i[cur_q]`.
- `lsu_req_header_o.val=0`.
- On `lsu_rsp_header_i.val && rsp_rdy_i[cur_q]`, the transaction completes and the state goes to IDLE. The registered op of `cur_q` then updates:
  - LOCK: `locked_q←1`, `owner_q←cur_q`; `rr_ptr_q` unchanged.
  - UNLOCK while `locked_q`: `locked_q←0`, `rr_ptr_q←cur_q+1 mod N_REQ`.
  - UNLOCK while not locked: forwarded normally; `err_o` pulses at completion; `rr_ptr_q←cur_q+1`.
  - LOAD / EDIT_SIZE_AND_NEXT_ADDR / EDIT_NEXT_ADDR: if not locked, `rr_ptr_q←cur_q+1`; if locked, `rr_ptr_q` frozen.

LOCAL_RSP:
- `rsp_header_o[cur_q]` = all-zero header with `.val=1`.
- On `rsp_rdy_i[cur_q]`: go to IDLE; lock state unchanged.

General rules:
- The op of the accepted request is held in a register for the BUSY update.
- Non-served `rsp_header_o[i]` are all-zero, including `.val`.
- At most one `req_ready_o` is high per cycle.
- At most one `rsp_header_o[i].val` is high per cycle.

## Timing
- Arbitration is combinational in IDLE: a request presented while the arbiter is IDLE and `lsu_ready_i`=1 is accepted the same cycle, adding zero cycles of latency.
- The response path is combinational pass-through in BUSY.
- Earliest back-to-back issue: the cycle after a completion, i.e. IDLE is held for at least one cycle between transactions.
- `req_header_i[i]` must stay stable with `.val` held until `req_ready_o[i]`. Dropping `.val` early is permitted and withdraws the request.
- While `rst_i`=1, and in the cycle after reset:
  - all outputs are 0;
  - `state_q=IDLE`, `rr_ptr_q=0`, `locked_q=0`, `owner_q=0`.
- Reset mid-transaction abandons `cur_q` and clears lock ownership; the LSU is reset by the same `rst_i`.
- Simultaneous requests: round-robin order only. Example: `N_REQ=2`, `rr_ptr_q=1`, both valid → requester 1 wins.

## Test plan
- Single LOAD: requester 0 LOAD, addr 0x40, LSU responds size 0x10, next_addr 0x80.
  - Expect `req_ready_o[0]` in the issue cycle.
  - Expect `rsp_header_o[0]` = {0x10, 0x80}; `rsp_header_o[1].val=0`.
- Fairness: both requesters hold LOAD continuously from reset; LSU always ready. Expect grant order 0,1,0,1 over 4 transactions.
- Lock exclusivity:
  - Requester 1 LOCK completes → `lock_held_o=1`, `lock_owner_o=1`.
  - Requester 0 LOAD stays pending (`req_ready_o[0]=0`) through requester 1's LOAD, EDIT_NEXT_ADDR and UNLOCK.
  - Requester 0 is granted the cycle after UNLOCK completes.
- Nested LOCK by the owner: expect `err_o` pulse, no LSU `.val`, a local zero response with `.val=1`; lock still held.
- Response backpressure: hold `rsp_rdy_i[0]=0` for 5 cycles.
  - Expect `lsu_core_rdy_o=0` and the response held stable.
  - Completion occurs in the cycle `rsp_rdy_i[0]` rises.
- Reset mid-BUSY while locked: assert `rst_i` for 1 cycle. Expect `lock_held_o=0` and all outputs 0; the next request from requester 0 is granted.

Source files
------------

// File: rtl/falafel_lsu_arbiter.sv
// falafel_lsu_arbiter: shares one falafel LSU core-side port between N_REQ
// requesters. Round-robin per transaction; a completed LOCK gives the owner
// exclusive use of the LSU until its UNLOCK completes.

package falafel_pkg;
  typedef enum logic [2:0] {
    OP_LOAD                    = 3'd0,
    OP_LOCK                    = 3'd1,
    OP_UNLOCK                  = 3'd2,
    OP_EDIT_SIZE_AND_NEXT_ADDR = 3'd3,
    OP_EDIT_NEXT_ADDR          = 3'd4
  } lsu_op_e;

  typedef struct packed {
    logic [31:0] size;
    logic [31:0] next_addr;
  } header_t;

  typedef struct packed {
    logic    val;
    lsu_op_e lsu_op;
    logic [31:0] addr;
    header_t header;
  } header_req_t;

  typedef struct packed {
    logic    val;
    header_t header;
  } header_rsp_t;
endpackage

module falafel_lsu_arbiter
  import falafel_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  header_req_t [N_REQ-1:0]  req_header_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output header_rsp_t [N_REQ-1:0]  rsp_header_o,
  input  logic [N_REQ-1:0]         rsp_rdy_i,
  output header_req_t              lsu_req_header_o,
  input  logic                     lsu_ready_i,
  input  header_rsp_t              lsu_rsp_header_i,
  output logic                     lsu_core_rdy_o,
  output logic                     lock_held_o,
  output logic [IDX_W-1:0]         lock_owner_o,
  output logic                     err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_LOCAL_RSP} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cur_q, cur_d;
  lsu_op_e          op_q, op_d;
  logic [IDX_W-1:0] rr_ptr_q;
  logic             locked_q;
  logic [IDX_W-1:0] owner_q;
  // High for the first cycle out of reset: the arbiter stays silent then.
  logic             wake_q;

  logic             found;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand_idx;
  int               cand;
  logic             complete;
  logic [IDX_W-1:0] cur_next;

  assign cur_next = (cur_q == IDX_W'(N_REQ - 1)) ? '0 : cur_q + IDX_W'(1);

  // Round-robin pick, FSM next state and all port outputs.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through this block can leave one unassigned and infer a latch.
    state_d          = state_q;
    cur_d            = cur_q;
    op_d             = op_q;
    req_ready_o      = '0;
    rsp_header_o     = '0;
    lsu_req_header_o = '0;
    lsu_core_rdy_o   = 1'b0;
    err_o            = 1'b0;
    complete         = 1'b0;
    found            = 1'b0;
    win              = '0;
    cand             = 0;
    cand_idx         = '0;

    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req_header_i[cand_idx].val &&
          (!locked_q || cand_idx == owner_q)) begin
        found = 1'b1;
        win   = cand_idx;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (found && !wake_q) begin
          if (locked_q && req_header_i[win].lsu_op == OP_LOCK) begin
            // Nested LOCK would spin the LSU forever: answer it locally.
            req_ready_o[win] = 1'b1;
            err_o            = 1'b1;
            cur_d            = win;
            state_d          = ST_LOCAL_RSP;
          end else if (lsu_ready_i) begin
            lsu_req_header_o     = req_header_i[win];
            lsu_req_header_o.val = 1'b1;
            req_ready_o[win]     = 1'b1;
            cur_d                = win;
            op_d                 = req_header_i[win].lsu_op;
            state_d              = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        rsp_header_o[cur_q] = lsu_rsp_header_i;
        lsu_core_rdy_o      = rsp_rdy_i[cur_q];
        if (lsu_rsp_header_i.val && rsp_rdy_i[cur_q]) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
          if (op_q == OP_UNLOCK && !locked_q) err_o = 1'b1;
        end
      end
      ST_LOCAL_RSP: begin
        rsp_header_o[cur_q].val = 1'b1;
        if (rsp_rdy_i[cur_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rst_i) begin
      req_ready_o      = '0;
      rsp_header_o     = '0;
      lsu_req_header_o = '0;
      lsu_core_rdy_o   = 1'b0;
      err_o            = 1'b0;
    end
  end

  assign lock_held_o  = locked_q & ~rst_i;
  assign lock_owner_o = rst_i ? '0 : owner_q;

  // State registers; lock and round-robin pointer update on LSU completion.
  always_ff @(posedge clk_i) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      op_q     <= OP_LOAD;
      rr_ptr_q <= '0;
      locked_q <= 1'b0;
      owner_q  <= '0;
      wake_q   <= 1'b1;
    end else begin
      wake_q  <= 1'b0;
      state_q <= state_d;
      cur_q   <= cur_d;
      op_q    <= op_d;
      if (complete) begin
        case (op_q)
          OP_LOCK: begin
            locked_q <= 1'b1;
            owner_q  <= cur_q;
          end
          OP_UNLOCK: begin
            locked_q <= 1'b0;
            rr_ptr_q <= cur_next;
          end
          default: begin
            if (!locked_q) rr_ptr_q <= cur_next;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_falafel_lsu_arbiter.sv
// Scoreboard bench for falafel_lsu_arbiter (N_REQ=2). Stimulus pushes the
// expected grants and responses; a negedge monitor pops and compares them.
// The LSU stand-in answers each request one cycle later with
// size = addr>>2, next_addr = addr<<1.

module tb_falafel_lsu_arbiter;
  import falafel_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  header_req_t [1:0]     req_header_i = '0;
  logic [1:0]            req_ready_o;
  header_rsp_t [1:0]     rsp_header_o;
  logic [1:0]            rsp_rdy_i = 2'b11;
  header_req_t           lsu_req_header_o;
  logic                  lsu_ready_i = 1'b1;
  header_rsp_t           lsu_rsp_header_i = '0;
  logic                  lsu_core_rdy_o;
  logic                  lock_held_o;
  logic [0:0]            lock_owner_o;
  logic                  err_o;

  falafel_lsu_arbiter #(.N_REQ(2)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_header_i     (req_header_i),
    .req_ready_o      (req_ready_o),
    .rsp_header_o     (rsp_header_o),
    .rsp_rdy_i        (rsp_rdy_i),
    .lsu_req_header_o (lsu_req_header_o),
    .lsu_ready_i      (lsu_ready_i),
    .lsu_rsp_header_i (lsu_rsp_header_i),
    .lsu_core_rdy_o   (lsu_core_rdy_o),
    .lock_held_o      (lock_held_o),
    .lock_owner_o     (lock_owner_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          idx;
    lsu_op_e     op;
    logic [31:0] addr;
    bit          nested;
  } grant_t;

  typedef struct {
    int          idx;
    logic [31:0] size;
    logic [31:0] next_addr;
  } rsp_t;

  grant_t exp_grant[$];
  rsp_t   exp_rsp[$];
  int     n_checks = 0;
  int     n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic outs_nonzero();
    return |{req_ready_o, rsp_header_o, lsu_req_header_o, lsu_core_rdy_o,
             lock_held_o, lock_owner_o, err_o};
  endfunction

  // LSU stand-in: sample handshakes mid-cycle, update just after the edge.
  bit          fire_req, fire_rsp, rst_s;
  logic [31:0] fire_addr;
  always @(negedge clk_i) begin
    fire_req  = lsu_req_header_o.val && lsu_ready_i;
    fire_rsp  = lsu_rsp_header_i.val && lsu_core_rdy_o;
    fire_addr = lsu_req_header_o.addr;
    rst_s     = rst_i;
  end
  always @(posedge clk_i) begin
    #1;
    if (rst_s) lsu_rsp_header_i = '0;
    else begin
      if (fire_rsp) lsu_rsp_header_i = '0;
      if (fire_req) begin
        lsu_rsp_header_i.val              = 1'b1;
        lsu_rsp_header_i.header.size      = fire_addr >> 2;
        lsu_rsp_header_i.header.next_addr = fire_addr << 1;
      end
    end
  end

  // Monitor: compare every grant and every response handshake in order.
  grant_t g;
  rsp_t   r;
  always @(negedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (req_ready_o[i]) begin
        if (exp_grant.size() == 0) check("grant_unexpected", 64'(i), 64'hdead);
        else begin
          g = exp_grant.pop_front();
          check("grant_idx", 64'(i), 64'(g.idx));
          if (g.nested) begin
            check("nested_err", 64'(err_o), 64'd1);
            check("nested_no_lsu", 64'(lsu_req_header_o.val), 64'd0);
          end else begin
            check("grant_no_err", 64'(err_o), 64'd0);
            check("fwd_val", 64'(lsu_req_header_o.val), 64'd1);
            check("fwd_op", 64'(lsu_req_header_o.lsu_op), 64'(g.op));
            check("fwd_addr", 64'(lsu_req_header_o.addr), 64'(g.addr));
          end
        end
      end
      if (rsp_header_o[i].val && rsp_rdy_i[i]) begin
        if (exp_rsp.size() == 0) check("rsp_unexpected", 64'(i), 64'hdead);
        else begin
          r = exp_rsp.pop_front();
          check("rsp_idx", 64'(i), 64'(r.idx));
          check("rsp_size", 64'(rsp_header_o[i].header.size), 64'(r.size));
          check("rsp_next", 64'(rsp_header_o[i].header.next_addr), 64'(r.next_addr));
          check("rsp_other_zero", 64'(rsp_header_o[1-i]), 64'd0);
        end
      end
    end
  end

  task automatic push_exp(input int idx, input lsu_op_e op, input logic [31:0] addr,
                          input bit nested, input logic [31:0] sz, input logic [31:0] nx);
    exp_grant.push_back('{idx: idx, op: op, addr: addr, nested: nested});
    exp_rsp.push_back('{idx: idx, size: sz, next_addr: nx});
  endtask

  task automatic drive_req(input int idx, input lsu_op_e op, input logic [31:0] addr);
    req_header_i[idx]        = '0;
    req_header_i[idx].val    = 1'b1;
    req_header_i[idx].lsu_op = op;
    req_header_i[idx].addr   = addr;
  endtask

  task automatic wait_grant(input int idx);
    bit got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk_i);
      if (req_ready_o[idx]) got = 1;
    end
    if (!got) check("grant_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(posedge clk_i);
      if (exp_rsp.size() == 0) done = 1;
    end
    if (!done) check("rsp_timeout", 64'(exp_rsp.size()), 64'd0);
    #1;
  endtask

  task automatic issue(input int idx, input lsu_op_e op, input logic [31:0] addr,
                       input bit nested, input logic [31:0] sz, input logic [31:0] nx);
    push_exp(idx, op, addr, nested, sz, nx);
    drive_req(idx, op, addr);
    wait_grant(idx);
    @(posedge clk_i); #1;
    req_header_i[idx].val = 1'b0;
    wait_drain();
  endtask

  task automatic do_reset(input int n);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    repeat (n) begin
      @(negedge clk_i);
      check("rst_outs_zero", 64'(outs_nonzero()), 64'd0);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_outs_zero", 64'(outs_nonzero()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $finish;
  end

  initial begin
    // Reset with a request already pending: it must stay unanswered.
    drive_req(0, OP_LOAD, 32'h40);
    do_reset(3);

    // Single LOAD.
    push_exp(0, OP_LOAD, 32'h40, 1'b0, 32'h10, 32'h80);
    wait_grant(0);
    @(posedge clk_i); #1;
    req_header_i[0].val = 1'b0;
    wait_drain();

    // Fairness from reset: both hold LOAD, expect 0,1,0,1.
    do_reset(1);
    for (int k = 0; k < 2; k++) begin
      push_exp(0, OP_LOAD, 32'h100, 1'b0, 32'h40, 32'h200);
      push_exp(1, OP_LOAD, 32'h200, 1'b0, 32'h80, 32'h400);
    end
    drive_req(0, OP_LOAD, 32'h100);
    drive_req(1, OP_LOAD, 32'h200);
    begin
      int grants = 0;
      for (int k = 0; k < 60 && grants < 4; k++) begin
        @(negedge clk_i);
        if (|req_ready_o) grants++;
      end
      check("fair_grants", 64'(grants), 64'd4);
    end
    @(posedge clk_i); #1;
    req_header_i[0].val = 1'b0;
    req_header_i[1].val = 1'b0;
    wait_drain();

    // Lock exclusivity: requester 1 locks, requester 0 waits.
    issue(1, OP_LOCK, 32'h10, 1'b0, 32'h4, 32'h20);
    check("lock_held", 64'(lock_held_o), 64'd1);
    check("lock_owner", 64'(lock_owner_o), 64'd1);
    drive_req(0, OP_LOAD, 32'h40);
    issue(1, OP_LOAD, 32'h20, 1'b0, 32'h8, 32'h40);
    check("locked_r0_wait", 64'(req_ready_o[0]), 64'd0);
    issue(1, OP_EDIT_NEXT_ADDR, 32'h30, 1'b0, 32'hc, 32'h60);
    issue(1, OP_UNLOCK, 32'h34, 1'b0, 32'hd, 32'h68);
    push_exp(0, OP_LOAD, 32'h40, 1'b0, 32'h10, 32'h80);
    @(negedge clk_i);
    check("r0_grant_after_unlock", 64'(req_ready_o[0]), 64'd1);
    check("unlocked", 64'(lock_held_o), 64'd0);
    @(posedge clk_i); #1;
    req_header_i[0].val = 1'b0;
    wait_drain();

    // Nested LOCK by the owner: local zero response, error pulse.
    issue(0, OP_LOCK, 32'h50, 1'b0, 32'h14, 32'ha0);
    issue(0, OP_LOCK, 32'h58, 1'b1, 32'h0, 32'h0);
    check("nested_lock_held", 64'(lock_held_o), 64'd1);
    check("nested_lock_owner", 64'(lock_owner_o), 64'd0);

    // Response backpressure for 5 cycles.
    rsp_rdy_i[0] = 1'b0;
    push_exp(0, OP_LOAD, 32'h60, 1'b0, 32'h18, 32'hc0);
    drive_req(0, OP_LOAD, 32'h60);
    wait_grant(0);
    @(posedge clk_i); #1;
    req_header_i[0].val = 1'b0;
    repeat (5) begin
      @(negedge clk_i);
      check("bp_core_rdy", 64'(lsu_core_rdy_o), 64'd0);
      check("bp_rsp_hold", 64'(rsp_header_o[0]), {31'd0, 1'b1, 32'h18, 32'hc0});
    end
    @(posedge clk_i); #1;
    rsp_rdy_i[0] = 1'b1;
    @(negedge clk_i);
    check("bp_release", 64'(lsu_core_rdy_o), 64'd1);
    wait_drain();

    // Reset mid-BUSY while locked.
    rsp_rdy_i[0] = 1'b0;
    exp_grant.push_back('{idx: 0, op: OP_EDIT_SIZE_AND_NEXT_ADDR, addr: 32'h70, nested: 1'b0});
    drive_req(0, OP_EDIT_SIZE_AND_NEXT_ADDR, 32'h70);
    wait_grant(0);
    @(posedge clk_i); #1;
    req_header_i[0].val = 1'b0;
    @(negedge clk_i);
    check("pre_rst_locked", 64'(lock_held_o), 64'd1);
    do_reset(1);
    check("rst_unlocked", 64'(lock_held_o), 64'd0);
    rsp_rdy_i[0] = 1'b1;
    issue(0, OP_LOAD, 32'h80, 1'b0, 32'h20, 32'h100);

    check("grant_queue_empty", 64'(exp_grant.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
